mc_ctrl_fsm: RTL and testbench

Multicycle control sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and write enable around the immediate generator, ALU, PC, IR and register file. Owns the memory request handshake with a timeout, and traps on illegal opcodes. Sits beside the datapath and decodes the registered instruction.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_decode.sv | 29 ++
 rtl/mc_ctrl_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control sequencer:
// FSM state encoding, RV32I major opcodes, datapath select encodings and
// the opcode-class record produced by the decoder.
package ctrl_pkg;

  // Encoding is visible on o_state, so the values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4     = 2'd0,
    PC_ALU       = 2'd1,
    PC_ALU_ALIGN = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    A_RS1   = 2'd0,
    A_OLDPC = 2'd1,
    A_ZERO  = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MDR = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

  // RV32I major opcodes accepted by the core (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // One-hot instruction class; exactly one field is set for any opcode.
  typedef struct packed {
    logic is_op;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic is_fence;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-class decoder. Anything outside the supported
// RV32I opcode set (including SYSTEM and compressed encodings where
// instr[1:0] != 2'b11) is flagged illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class
);

  // Map the major opcode onto a single class bit.
  always_comb begin
    o_class = '0;
    case (i_opcode)
      OPC_OP:     o_class.is_op     = 1'b1;
      OPC_OP_IMM: o_class.is_imm    = 1'b1;
      OPC_LOAD:   o_class.is_load   = 1'b1;
      OPC_STORE:  o_class.is_store  = 1'b1;
      OPC_BRANCH: o_class.is_branch = 1'b1;
      OPC_JAL:    o_class.is_jal    = 1'b1;
      OPC_JALR:   o_class.is_jalr   = 1'b1;
      OPC_LUI:    o_class.is_lui    = 1'b1;
      OPC_AUIPC:  o_class.is_auipc  = 1'b1;
      OPC_FENCE:  o_class.is_fence  = 1'b1;
      default:    o_class.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects and write
// enables, owns the memory request handshake (with timeout) and traps on
// illegal opcodes or bus timeouts.
//
// Memory handshake: o_mem_req rises in FETCH/MEM and stays high, with
// o_mem_we and o_mem_is_fetch stable, until a cycle in which i_mem_ack is
// high; that cycle completes the transfer (ack may come in the very first
// request cycle). i_mem_ack is ignored whenever o_mem_req is low.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_taken,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_is_fetch,
  output logic        o_ir_we,
  output logic        o_oldpc_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic [1:0]  o_a_sel,
  output logic        o_b_sel,
  output logic        o_alu_add,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [2:0]  o_state
);

  // Counter is at least 8 bits, wider only if the timeout needs it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  op_class_t cls;
  logic      timeout_hit;

  // Ungated datapath controls, decoded from state and instruction.
  logic    mem_req, mem_we, mem_is_fetch;
  logic    ir_we, oldpc_we, pc_we;
  pc_sel_e pc_sel;
  a_sel_e  a_sel;
  logic    b_sel, alu_add, rf_we;
  wb_sel_e wb_sel;

  // Only the major opcode steers the sequencer; funct fields go to the ALU.
  logic unused_instr_bits;
  assign unused_instr_bits = ^i_instr[31:7];

  ctrl_decode u_decode (
    .i_opcode (i_instr[6:0]),
    .o_class  (cls)
  );

  // The current request cycle is the last one allowed without an ack.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // Next-state, timeout counter and per-state output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    oldpc_we     = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    a_sel        = A_RS1;
    b_sel        = 1'b0;
    alu_add      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (i_mem_ack) begin
          ir_we    = 1'b1;
          oldpc_we = 1'b1;
          pc_we    = 1'b1;
          pc_sel   = PC_PLUS4;
          state_d  = ST_DECODE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DECODE: begin
        if (cls.illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cls.is_op) begin
          a_sel   = A_RS1;
          b_sel   = 1'b0;
          state_d = ST_WB;
        end else if (cls.is_imm) begin
          a_sel   = A_RS1;
          b_sel   = 1'b1;
          state_d = ST_WB;
        end else if (cls.is_lui) begin
          a_sel   = A_ZERO;
          b_sel   = 1'b1;
          alu_add = 1'b1;
          state_d = ST_WB;
        end else if (cls.is_auipc) begin
          a_sel   = A_OLDPC;
          b_sel   = 1'b1;
          alu_add = 1'b1;
          state_d = ST_WB;
        end else if (cls.is_load || cls.is_store) begin
          a_sel   = A_RS1;
          b_sel   = 1'b1;
          alu_add = 1'b1;
          state_d = ST_MEM;
        end else if (cls.is_branch) begin
          a_sel   = A_OLDPC;
          b_sel   = 1'b1;
          alu_add = 1'b1;
          pc_sel  = PC_ALU;
          pc_we   = i_br_taken;
          state_d = ST_FETCH;
        end else if (cls.is_jal || cls.is_jalr) begin
          // Link value is the PC before this edge (OLDPC+4); the new PC is
          // the ALU target, low bit cleared for JALR.
          a_sel   = cls.is_jal ? A_OLDPC : A_RS1;
          b_sel   = 1'b1;
          alu_add = 1'b1;
          pc_sel  = cls.is_jal ? PC_ALU : PC_ALU_ALIGN;
          pc_we   = 1'b1;
          rf_we   = 1'b1;
          wb_sel  = WB_PC;
          state_d = ST_FETCH;
        end else if (cls.is_fence) begin
          state_d = ST_FETCH;
        end else begin
          // IR changed under us after DECODE accepted it; stop the core.
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls.is_store;
        if (i_mem_ack) begin
          state_d = cls.is_store ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB: begin
        rf_we   = 1'b1;
        wb_sel  = cls.is_load ? WB_MDR : WB_ALU;
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // State, timeout counter and sticky trap flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // While reset is asserted every output is forced low, so an in-flight
  // request is abandoned in the same cycle and no write enable can fire.
  assign o_mem_req      = i_rst_n & mem_req;
  assign o_mem_we       = i_rst_n & mem_we;
  assign o_mem_is_fetch = i_rst_n & mem_is_fetch;
  assign o_ir_we        = i_rst_n & ir_we;
  assign o_oldpc_we     = i_rst_n & oldpc_we;
  assign o_pc_we        = i_rst_n & pc_we;
  assign o_pc_sel       = i_rst_n ? pc_sel : PC_PLUS4;
  assign o_a_sel        = i_rst_n ? a_sel : A_RS1;
  assign o_b_sel        = i_rst_n & b_sel;
  assign o_alu_add      = i_rst_n & alu_add;
  assign o_rf_we        = i_rst_n & rf_we;
  assign o_wb_sel       = i_rst_n ? wb_sel : WB_ALU;
  assign o_illegal      = i_rst_n & illegal_q;
  assign o_bus_err      = i_rst_n & bus_err_q;
  assign o_state        = i_rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm (timeout set to 4 cycles).
// Directed per-cycle sequences, a table of per-instruction expectations,
// and randomized instructions/ack latencies checked against an
// instruction-level cost model.
module tb_mc_ctrl_fsm;

  localparam int TMO = 4;
  localparam int NEVER = 99;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic        i_br_taken = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic        o_mem_req, o_mem_we, o_mem_is_fetch, o_ir_we, o_oldpc_we, o_pc_we;
  logic [1:0]  o_pc_sel, o_a_sel, o_wb_sel;
  logic        o_b_sel, o_alu_add, o_rf_we, o_illegal, o_bus_err;
  logic [2:0]  o_state;

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_br_taken(i_br_taken),
    .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_is_fetch(o_mem_is_fetch), .o_ir_we(o_ir_we), .o_oldpc_we(o_oldpc_we),
    .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_a_sel(o_a_sel), .o_b_sel(o_b_sel),
    .o_alu_add(o_alu_add), .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel),
    .o_illegal(o_illegal), .o_bus_err(o_bus_err), .o_state(o_state)
  );

  // Clock and watchdog.
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  wire [19:0] all_o = {o_mem_req, o_mem_we, o_mem_is_fetch, o_ir_we, o_oldpc_we, o_pc_we,
                       o_pc_sel, o_a_sel, o_b_sel, o_alu_add, o_rf_we, o_wb_sel,
                       o_illegal, o_bus_err, o_state};
  wire [5:0]  en_o  = {o_mem_req, o_mem_we, o_ir_we, o_oldpc_we, o_pc_we, o_rf_we};

  int n_tests = 0;
  int n_fail  = 0;
  int rq      = 0;   // request cycles seen by the memory responder

  logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge. The memory responder acks on the
  // (wait+1)-th request cycle; with noise, ack toggles randomly while idle.
  task automatic apply(input logic [31:0] instr, input logic br,
                       input int fw, input int mw, input bit noise);
    int tgt;
    @(negedge i_clk);
    i_rst_n    = 1'b1;
    i_instr    = instr;
    i_br_taken = br;
    i_mem_ack  = 1'b0;
    #1;
    if (o_mem_req) begin
      tgt       = o_mem_is_fetch ? fw : mw;
      i_mem_ack = (rq == tgt);
      rq        = i_mem_ack ? 0 : rq + 1;
    end else begin
      rq        = 0;
      i_mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #1;
  endtask

  // Reset cycle with ack held high: every output must be low immediately,
  // then the core must come back in FETCH with clean trap flags.
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n   = 1'b0;
    i_mem_ack = 1'b1;
    #1;
    chk("rst_outputs_zero", all_o, 0);
    @(posedge i_clk);
    #1;
    i_rst_n   = 1'b1;
    i_mem_ack = 1'b0;
    rq        = 0;
    #1;
    chk("rst_state_fetch", o_state, 0);
    chk("rst_flags_clear", {o_illegal, o_bus_err}, 0);
  endtask

  // Run one instruction from FETCH until the core is back in FETCH or traps,
  // tallying enables and request cycles.
  task automatic run_instr(input logic [31:0] instr, input logic br, input int fw,
                           input int mw, input bit noise,
                           output int cyc, output int rf, output int pcwe,
                           output int req, output int we, output int st);
    bit seen = 0;
    cyc = 0; rf = 0; pcwe = 0; req = 0; we = 0; st = 0;
    while (cyc < 60) begin
      apply(instr, br, fw, mw, noise);
      cyc++;
      if (o_state != 3'd0) seen = 1;
      rf   += int'(o_rf_we);
      pcwe += int'(o_pc_we);
      req  += int'(o_mem_req);
      we   += int'(o_mem_we);
      @(posedge i_clk);
      #1;
      st = int'(o_state);
      if (st == 7 || (seen && st == 0)) break;
    end
  endtask

  // Instruction-level cost model: cycle and enable counts follow from the
  // phase costs (fetch, decode, exec, optional mem, optional writeback).
  function automatic void model(input logic [31:0] instr, input logic br,
                                input int fw, input int mw,
                                output int cyc, output int rf, output int pcwe,
                                output int req, output int we, output int st,
                                output int ill, output int berr);
    logic [6:0] op;
    bit legal;
    int mc;
    op = instr[6:0];
    legal = 0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1;
    cyc = 0; rf = 0; pcwe = 0; req = 0; we = 0; st = 0; ill = 0; berr = 0;
    if (fw >= TMO) begin
      cyc = TMO; req = TMO; st = 7; berr = 1;
      return;
    end
    cyc  = fw + 2;
    req  = fw + 1;
    pcwe = 1;
    if (!legal) begin
      st = 7; ill = 1;
      return;
    end
    cyc += 1;
    case (op)
      7'h63: pcwe += int'(br);
      7'h6F, 7'h67: begin pcwe += 1; rf += 1; end
      7'h0F: ;
      7'h03, 7'h23: begin
        mc   = (mw >= TMO) ? TMO : mw + 1;
        cyc += mc;
        req += mc;
        if (op == 7'h23) we = mc;
        if (mw >= TMO) begin
          st = 7; berr = 1;
        end else if (op == 7'h03) begin
          cyc += 1; rf += 1;
        end
      end
      default: begin cyc += 1; rf += 1; end
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        br;
    int          fw, mw;
    int          cyc, rf, pcwe, req, we, st, ill, berr;
  } vec_t;

  initial begin
    vec_t vt [20];
    int cyc, rf, pcwe, req, we, st;
    int e_cyc, e_rf, e_pcwe, e_req, e_we, e_st, e_ill, e_berr;

    //            instr         br fw     mw     cyc rf pcwe req we st ill berr
    vt[0]  = '{32'h00500093, 0, 0,     0,     4, 1, 1, 1, 0, 0, 0, 0};  // ADDI
    vt[1]  = '{32'h002081B3, 0, 0,     0,     4, 1, 1, 1, 0, 0, 0, 0};  // ADD
    vt[2]  = '{32'h123450B7, 0, 0,     0,     4, 1, 1, 1, 0, 0, 0, 0};  // LUI
    vt[3]  = '{32'h00001097, 0, 0,     0,     4, 1, 1, 1, 0, 0, 0, 0};  // AUIPC
    vt[4]  = '{32'h00002083, 0, 0,     3,     8, 1, 1, 5, 0, 0, 0, 0};  // LW slow
    vt[5]  = '{32'h00002083, 0, 0,     0,     5, 1, 1, 2, 0, 0, 0, 0};  // LW
    vt[6]  = '{32'h00102023, 0, 0,     0,     4, 0, 1, 2, 1, 0, 0, 0};  // SW
    vt[7]  = '{32'h00102023, 0, 0,     3,     7, 0, 1, 5, 4, 0, 0, 0};  // SW slow
    vt[8]  = '{32'h00000063, 0, 0,     0,     3, 0, 1, 1, 0, 0, 0, 0};  // BEQ nt
    vt[9]  = '{32'h00000063, 1, 0,     0,     3, 0, 2, 1, 0, 0, 0, 0};  // BEQ t
    vt[10] = '{32'h008000EF, 0, 0,     0,     3, 1, 2, 1, 0, 0, 0, 0};  // JAL
    vt[11] = '{32'h000080E7, 0, 0,     0,     3, 1, 2, 1, 0, 0, 0, 0};  // JALR
    vt[12] = '{32'h0000000F, 0, 0,     0,     3, 0, 1, 1, 0, 0, 0, 0};  // FENCE
    vt[13] = '{32'h00500093, 0, 2,     0,     6, 1, 1, 3, 0, 0, 0, 0};  // fetch wait 2
    vt[14] = '{32'h00500093, 0, 3,     0,     7, 1, 1, 4, 0, 0, 0, 0};  // ack on 4th
    vt[15] = '{32'h00000073, 0, 0,     0,     2, 0, 1, 1, 0, 7, 1, 0};  // ECALL
    vt[16] = '{32'h00500090, 0, 0,     0,     2, 0, 1, 1, 0, 7, 1, 0};  // [1:0]!=11
    vt[17] = '{32'h00500093, 0, NEVER, 0,     4, 0, 0, 4, 0, 7, 0, 1};  // fetch tmo
    vt[18] = '{32'h00002083, 0, 0,     NEVER, 7, 0, 1, 5, 0, 7, 0, 1};  // LW tmo
    vt[19] = '{32'h00102023, 0, 0,     NEVER, 7, 0, 1, 5, 4, 7, 0, 1};  // SW tmo

    do_reset();

    // ADDI with zero-wait memory: states 0,1,2,4 then back to 0.
    apply(32'h00500093, 0, 0, 0, 0);
    chk("addi_f_state", o_state, 0);
    chk("addi_f_ctl", {o_mem_req, o_mem_is_fetch, o_ir_we, o_oldpc_we, o_pc_we, o_pc_sel}, 7'b1111100);
    apply(32'h00500093, 0, 0, 0, 0);
    chk("addi_d_state", o_state, 1);
    chk("addi_d_en", en_o, 0);
    apply(32'h00500093, 0, 0, 0, 0);
    chk("addi_e_state", o_state, 2);
    chk("addi_e_ctl", {o_a_sel, o_b_sel, o_alu_add, o_rf_we, o_pc_we}, 6'b001000);
    apply(32'h00500093, 0, 0, 0, 0);
    chk("addi_wb_state", o_state, 4);
    chk("addi_wb_ctl", {o_rf_we, o_wb_sel}, 3'b100);
    @(posedge i_clk); #1;
    chk("addi_next_fetch", o_state, 0);

    // JALR and JAL in their EXEC cycle.
    repeat (3) apply(32'h000080E7, 0, 0, 0, 0);
    chk("jalr_e_ctl", {o_pc_sel, o_pc_we, o_rf_we, o_wb_sel, o_a_sel, o_b_sel, o_alu_add}, 11'b10_1_1_10_00_1_1);
    @(posedge i_clk); #1;
    chk("jalr_next_fetch", o_state, 0);
    repeat (3) apply(32'h008000EF, 0, 0, 0, 0);
    chk("jal_e_ctl", {o_pc_sel, o_pc_we, o_rf_we, o_wb_sel, o_a_sel, o_b_sel, o_alu_add}, 11'b01_1_1_10_01_1_1);

    // BEQ not taken then taken.
    repeat (3) apply(32'h00000063, 0, 0, 0, 0);
    chk("beq_nt_ctl", {o_pc_sel, o_pc_we, o_rf_we, o_a_sel, o_b_sel, o_alu_add}, 8'b01_0_0_01_1_1);
    repeat (3) apply(32'h00000063, 1, 0, 0, 0);
    chk("beq_t_ctl", {o_pc_sel, o_pc_we, o_rf_we, o_a_sel, o_b_sel, o_alu_add}, 8'b01_1_0_01_1_1);

    // LW with 3 wait states in MEM, then WB selecting MDR.
    repeat (3) apply(32'h00002083, 0, 0, 3, 0);
    chk("lw_e_ctl", {o_a_sel, o_b_sel, o_alu_add}, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      apply(32'h00002083, 0, 0, 3, 0);
      chk("lw_mem_state", o_state, 3);
      chk("lw_mem_ctl", {o_mem_req, o_mem_is_fetch, o_mem_we}, 3'b100);
    end
    apply(32'h00002083, 0, 0, 3, 0);
    chk("lw_wb_ctl", {o_state, o_rf_we, o_wb_sel}, {3'd4, 1'b1, 2'd1});

    // SW drives a store request in MEM.
    repeat (4) apply(32'h00102023, 0, 0, 0, 0);
    chk("sw_mem_ctl", {o_state, o_mem_req, o_mem_is_fetch, o_mem_we}, {3'd3, 3'b101});

    // ECALL traps after DECODE and stays put with no requests.
    repeat (2) apply(32'h00000073, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    chk("ecall_trap_state", o_state, 7);
    chk("ecall_illegal", o_illegal, 1);
    for (int i = 0; i < 4; i++) begin
      apply(32'h00000073, 0, 0, 0, 1);
      chk("trap_hold", {o_state, en_o, o_illegal}, {3'd7, 6'b0, 1'b1});
    end
    do_reset();

    // Reset in the middle of a stalled MEM request.
    repeat (4) apply(32'h00002083, 0, 0, NEVER, 0);
    chk("midmem_req", {o_state, o_mem_req}, {3'd3, 1'b1});
    do_reset();

    // Table of per-instruction expectations.
    foreach (vt[i]) begin
      run_instr(vt[i].instr, vt[i].br, vt[i].fw, vt[i].mw, 0, cyc, rf, pcwe, req, we, st);
      chk($sformatf("tbl%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("tbl%0d_rf_we", i), rf, vt[i].rf);
      chk($sformatf("tbl%0d_pc_we", i), pcwe, vt[i].pcwe);
      chk($sformatf("tbl%0d_req", i), req, vt[i].req);
      chk($sformatf("tbl%0d_we", i), we, vt[i].we);
      chk($sformatf("tbl%0d_state", i), st, vt[i].st);
      chk($sformatf("tbl%0d_flags", i), {o_illegal, o_bus_err}, {vt[i].ill[0], vt[i].berr[0]});
      if (st == 7 || vt[i].st == 7) do_reset();
    end

    // Random instructions and ack latencies against the cost model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] r, instr;
      logic [6:0]  op;
      logic        br;
      int          fw, mw, k;
      r  = $urandom();
      k  = $urandom_range(0, 11);
      op = (k < 10) ? legal_ops[k] : 7'($urandom_range(0, 127));
      instr = {r[31:7], op};
      br = 1'($urandom_range(0, 1));
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      run_instr(instr, br, fw, mw, 1, cyc, rf, pcwe, req, we, st);
      model(instr, br, fw, mw, e_cyc, e_rf, e_pcwe, e_req, e_we, e_st, e_ill, e_berr);
      chk($sformatf("rnd%0d_cycles(%h)", n, instr), cyc, e_cyc);
      chk($sformatf("rnd%0d_rf_we", n), rf, e_rf);
      chk($sformatf("rnd%0d_pc_we", n), pcwe, e_pcwe);
      chk($sformatf("rnd%0d_req", n), req, e_req);
      chk($sformatf("rnd%0d_we", n), we, e_we);
      chk($sformatf("rnd%0d_state", n), st, e_st);
      chk($sformatf("rnd%0d_flags", n), {o_illegal, o_bus_err}, {e_ill[0], e_berr[0]});
      if (st == 7 || e_st == 7) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
